ex_stage: RTL and testbench

Execute stage of the 16-bit pipeline: performs the ALU operation, resolves branches, and holds the EX/MEM pipeline register that directly feeds the memory stage. Its registered outputs AluResult, Immediate2, PC2, DataMemory and signals connect unchanged to the memory stage inputs of the same names. Single-cycle ops complete in one clock. MUL runs on an iterative 16-cycle shift-add engine that stalls the front end.

---
 rtl/ex_stage.sv | 214 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline with ALU, branch resolve,
// iterative 16-cycle shift-add multiplier and the EX/MEM pipeline register.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid, stall_in    : ID/EX valid, memory stage back-pressure
//   flush                 : kill EX/MEM contents and any in-flight MUL
//   ALUop, AluSrc         : operation select, second operand select
//   OperandA/B, Immediate : operands; PC : incremented PC
//   BranchType            : none/BEQ/BNE/BGT(signed)
//   sig_in, RegDst_in, RegWr_in : control passed through to memory stage
//   AluResult, Immediate2, PC2, DataMemory, signals, RegDst, RegWr, out_valid : EX/MEM register
//   busy      : multiplier occupied (registered)
//   stall_out : busy | stall_in, holds ID/EX upstream
//   taken     : combinational branch decision for the accepted instruction
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        stall_in,
    input  logic        flush,
    input  logic [2:0]  ALUop,
    input  logic [15:0] OperandA,
    input  logic [15:0] OperandB,
    input  logic [15:0] Immediate,
    input  logic        AluSrc,
    input  logic [15:0] PC,
    input  logic [1:0]  BranchType,
    input  logic [6:0]  sig_in,
    input  logic [2:0]  RegDst_in,
    input  logic        RegWr_in,
    output logic [15:0] AluResult,
    output logic [15:0] Immediate2,
    output logic [15:0] PC2,
    output logic [15:0] DataMemory,
    output logic [6:0]  signals,
    output logic [2:0]  RegDst,
    output logic        RegWr,
    output logic        out_valid,
    output logic        busy,
    output logic        stall_out,
    output logic        taken
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pcl_q, pcl_d, imml_q, imml_d, opbl_q, opbl_d;
    logic [6:0]  sigl_q, sigl_d;
    logic [2:0]  rdl_q, rdl_d;
    logic        rwl_q, rwl_d;
    logic [15:0] res_q, res_d, imm2_q, imm2_d, pc2_q, pc2_d, dm_q, dm_d;
    logic [6:0]  sig_q, sig_d;
    logic [2:0]  rd_q, rd_d;
    logic        rw_q, rw_d, ov_q, ov_d;
    logic [15:0] opb, alu;
    logic        accept, cond, bub;

    assign opb = AluSrc ? Immediate : OperandB;
    assign accept = in_valid & ~busy & ~stall_in & ~flush;
    assign alu = ALUop == 3'b000 ? OperandA & opb :
                 ALUop == 3'b001 ? OperandA + opb :
                 ALUop == 3'b010 ? OperandA - opb :
                 ALUop == 3'b011 ? OperandA << opb[3:0] :
                 ALUop == 3'b100 ? OperandA >> opb[3:0] : opb;
    // Branches always compare the register operands, never the immediate.
    assign cond = BranchType == 2'b01 ? OperandA == OperandB :
                  BranchType == 2'b10 ? OperandA != OperandB :
                  BranchType == 2'b11 ? $signed(OperandA) > $signed(OperandB) : 1'b0;
    assign taken = accept & cond;
    assign busy = state_q != IDLE;
    assign stall_out = busy | stall_in;

    assign AluResult  = res_q;
    assign Immediate2 = imm2_q;
    assign PC2        = pc2_q;
    assign DataMemory = dm_q;
    assign signals    = sig_q;
    assign RegDst     = rd_q;
    assign RegWr      = rw_q;
    assign out_valid  = ov_q;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        pcl_d = pcl_q;
        imml_d = imml_q;
        opbl_d = opbl_q;
        sigl_d = sigl_q;
        rdl_d = rdl_q;
        rwl_d = rwl_q;
        res_d = res_q;
        imm2_d = imm2_q;
        pc2_d = pc2_q;
        dm_d = dm_q;
        sig_d = sig_q;
        rd_d = rd_q;
        rw_d = rw_q;
        ov_d = ov_q;
        bub = 1'b0;
        if (flush) begin
            state_d = IDLE;
            bub = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && ALUop == 3'b101) begin
                        mcand_d = OperandA;
                        mplier_d = opb;
                        acc_d = '0;
                        cnt_d = '0;
                        pcl_d = PC;
                        imml_d = Immediate;
                        opbl_d = OperandB;
                        sigl_d = sig_in;
                        rdl_d = RegDst_in;
                        rwl_d = RegWr_in;
                        bub = 1'b1;
                        state_d = MUL;
                    end else if (accept) begin
                        res_d = alu;
                        imm2_d = Immediate;
                        pc2_d = PC;
                        dm_d = OperandB;
                        sig_d = sig_in;
                        rd_d = RegDst_in;
                        rw_d = RegWr_in;
                        ov_d = 1'b1;
                    end else if (!stall_in) begin
                        bub = 1'b1;
                    end
                end
                // The engine iterates regardless of stall_in; EX/MEM already holds a bubble.
                MUL: begin
                    acc_d = acc_q + (mplier_q[0] ? mcand_q : 16'd0);
                    mcand_d = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15)
                        state_d = DONE;
                end
                DONE: begin
                    if (!stall_in) begin
                        res_d = acc_q;
                        imm2_d = imml_q;
                        pc2_d = pcl_q;
                        dm_d = opbl_q;
                        sig_d = sigl_q;
                        rd_d = rdl_q;
                        rw_d = rwl_q;
                        ov_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (bub) begin
            res_d = '0;
            imm2_d = '0;
            pc2_d = '0;
            dm_d = '0;
            sig_d = '0;
            rd_d = '0;
            rw_d = 1'b0;
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplier_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            pcl_q <= '0;
            imml_q <= '0;
            opbl_q <= '0;
            sigl_q <= '0;
            rdl_q <= '0;
            rwl_q <= 1'b0;
            res_q <= '0;
            imm2_q <= '0;
            pc2_q <= '0;
            dm_q <= '0;
            sig_q <= '0;
            rd_q <= '0;
            rw_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            pcl_q <= pcl_d;
            imml_q <= imml_d;
            opbl_q <= opbl_d;
            sigl_q <= sigl_d;
            rdl_q <= rdl_d;
            rwl_q <= rwl_d;
            res_q <= res_d;
            imm2_q <= imm2_d;
            pc2_q <= pc2_d;
            dm_q <= dm_d;
            sig_q <= sig_d;
            rd_q <= rd_d;
            rw_q <= rw_d;
            ov_q <= ov_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with a cycle-level reference model.
module tb_ex_stage;
    logic        clk = 1'b0, reset, in_valid, stall_in, flush, AluSrc, RegWr_in;
    logic [2:0]  ALUop, RegDst_in;
    logic [15:0] OperandA, OperandB, Immediate, PC;
    logic [1:0]  BranchType;
    logic [6:0]  sig_in;
    logic [15:0] AluResult, Immediate2, PC2, DataMemory;
    logic [6:0]  signals;
    logic [2:0]  RegDst;
    logic        RegWr, out_valid, busy, stall_out, taken;
    int n_vec = 0, n_bad = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .ALUop(ALUop), .OperandA(OperandA), .OperandB(OperandB), .Immediate(Immediate),
        .AluSrc(AluSrc), .PC(PC), .BranchType(BranchType), .sig_in(sig_in),
        .RegDst_in(RegDst_in), .RegWr_in(RegWr_in), .AluResult(AluResult),
        .Immediate2(Immediate2), .PC2(PC2), .DataMemory(DataMemory), .signals(signals),
        .RegDst(RegDst), .RegWr(RegWr), .out_valid(out_valid), .busy(busy),
        .stall_out(stall_out), .taken(taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: EX/MEM contents, and the multiplier as "busy with a
    // known product, N iterations elapsed".
    logic [15:0] e_res = 0, e_imm = 0, e_pc = 0, e_dm = 0;
    logic [6:0]  e_sig = 0;
    logic [2:0]  e_rd = 0;
    logic        e_rw = 0, e_ov = 0, m_busy = 0;
    int          m_iter = 0;
    logic [15:0] p_res, p_imm, p_pc, p_dm, m_b;
    logic [6:0]  p_sig;
    logic [2:0]  p_rd;
    logic        p_rw;
    logic [31:0] prod;

    task automatic mset(input logic [15:0] r, im, pc, dm, input logic [6:0] s,
                        input logic [2:0] rd, input logic rw, ov);
        e_res = r; e_imm = im; e_pc = pc; e_dm = dm; e_sig = s; e_rd = rd; e_rw = rw; e_ov = ov;
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, b);
        case (op)
            3'd0: return a & b;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a << b[3:0];
            3'd4: return a >> b[3:0];
            default: return b;
        endcase
    endfunction

    function automatic logic ref_taken();
        int sa, sb;
        logic c;
        sa = $signed(OperandA);
        sb = $signed(OperandB);
        c = BranchType == 2'd1 ? OperandA == OperandB :
            BranchType == 2'd2 ? OperandA != OperandB :
            BranchType == 2'd3 ? sa > sb : 1'b0;
        return in_valid && !m_busy && !stall_in && !flush && c;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mset(0, 0, 0, 0, 0, 0, 0, 0);
            m_busy = 0;
            m_iter = 0;
        end else begin
            m_b = AluSrc ? Immediate : OperandB;
            if (flush) begin
                mset(0, 0, 0, 0, 0, 0, 0, 0);
                m_busy = 0;
            end else if (m_busy) begin
                if (m_iter == 16) begin
                    if (!stall_in) begin
                        mset(p_res, p_imm, p_pc, p_dm, p_sig, p_rd, p_rw, 1);
                        m_busy = 0;
                    end
                end else begin
                    m_iter++;
                end
            end else if (in_valid && !stall_in) begin
                if (ALUop == 3'd5) begin
                    prod = {16'd0, OperandA} * {16'd0, m_b};
                    p_res = prod[15:0];
                    p_imm = Immediate; p_pc = PC; p_dm = OperandB;
                    p_sig = sig_in; p_rd = RegDst_in; p_rw = RegWr_in;
                    m_busy = 1;
                    m_iter = 0;
                    mset(0, 0, 0, 0, 0, 0, 0, 0);
                end else begin
                    mset(ref_alu(ALUop, OperandA, m_b), Immediate, PC, OperandB, sig_in, RegDst_in, RegWr_in, 1);
                end
            end else if (!stall_in) begin
                mset(0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_res", AluResult, e_res);
        chk("cyc_imm", Immediate2, e_imm);
        chk("cyc_pc", PC2, e_pc);
        chk("cyc_dm", DataMemory, e_dm);
        chk("cyc_sig", signals, e_sig);
        chk("cyc_rd", RegDst, e_rd);
        chk("cyc_rw", RegWr, e_rw);
        chk("cyc_ov", out_valid, e_ov);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_stall_out", stall_out, m_busy | stall_in);
        chk("cyc_taken", taken, ref_taken());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [2:0] op, input logic [15:0] a, b, imm,
                       input logic src, input logic [1:0] bt);
        in_valid = 1; ALUop = op; OperandA = a; OperandB = b; Immediate = imm;
        AluSrc = src; BranchType = bt;
    endtask

    logic seen;

    initial begin
        reset = 1; in_valid = 0; stall_in = 0; flush = 0; ALUop = 0; OperandA = 0;
        OperandB = 0; Immediate = 0; AluSrc = 0; PC = 0; BranchType = 0; sig_in = 0;
        RegDst_in = 0; RegWr_in = 0;
        repeat (2) step();
        reset = 0;
        sig_in = 7'h2A; RegDst_in = 3'd6; RegWr_in = 1; PC = 16'h0010;
        ins(3'd1, 16'h1234, 16'h1111, 16'h0, 0, 0);
        step();
        chk("pre_rst_ov", out_valid, 1);
        reset = 1; in_valid = 0;
        #1;
        chk("rst_res", AluResult, 0);
        chk("rst_sig", signals, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_busy", busy, 0);
        step();
        reset = 0;
        ins(3'd1, 16'h7FFF, 16'h0001, 16'h0, 0, 0);
        step();
        chk("add_res", AluResult, 16'h8000);
        chk("add_ov", out_valid, 1);
        sig_in = 7'h55; RegDst_in = 3'd5; RegWr_in = 1; PC = 16'h0040;
        ins(3'd2, 16'h0000, 16'h00AA, 16'h0001, 1, 0);
        step();
        chk("sub_res", AluResult, 16'hFFFF);
        chk("sub_sig", signals, 7'h55);
        chk("sub_rd", RegDst, 3'd5);
        chk("sub_pc", PC2, 16'h0040);
        chk("sub_imm", Immediate2, 16'h0001);
        chk("sub_dm", DataMemory, 16'h00AA);
        ins(3'd3, 16'h0001, 16'h0013, 16'h0, 0, 0);
        step();
        chk("sll_res", AluResult, 16'h0008);
        ins(3'd0, 16'hFFFF, 16'h0000, 16'h0, 0, 0);
        stall_in = 1;
        step();
        step();
        chk("stall_hold_res", AluResult, 16'h0008);
        chk("stall_hold_ov", out_valid, 1);
        stall_in = 0;
        step();
        chk("and_res", AluResult, 16'h0000);
        ins(3'd4, 16'h8000, 16'h0000, 16'h0004, 1, 0);
        step();
        chk("srl_res", AluResult, 16'h0800);
        ins(3'd6, 16'h1234, 16'h0000, 16'hBEEF, 1, 0);
        step();
        chk("passb_res", AluResult, 16'hBEEF);
        ins(3'd1, 16'h0001, 16'hFFFF, 16'h0, 0, 2'b11);
        #1;
        chk("bgt_taken", taken, 1);
        step();
        chk("bgt_add_res", AluResult, 16'h0000);
        in_valid = 0; BranchType = 0;
        step();
        chk("idle_ov", out_valid, 0);
        sig_in = 7'h7F; RegDst_in = 3'd3; RegWr_in = 1; PC = 16'h0100;
        ins(3'd5, 16'h0123, 16'h0010, 16'h0, 0, 0);
        step();
        in_valid = 0;
        chk("mul_t0_busy", busy, 1);
        chk("mul_t0_sig", signals, 0);
        chk("mul_t0_rw", RegWr, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) begin
                ins(3'd1, 16'h0005, 16'h0005, 16'h0, 0, 2'b01);
                #1;
                chk("beq_busy_taken", taken, 0);
            end
            step();
            in_valid = 0; BranchType = 0;
            chk("mul_busy", busy, 1);
            chk("mul_bubble_ov", out_valid, 0);
        end
        step();
        chk("mul_res", AluResult, 16'h1230);
        chk("mul_ov", out_valid, 1);
        chk("mul_busy_fall", busy, 0);
        chk("mul_pc", PC2, 16'h0100);
        chk("mul_sig", signals, 7'h7F);
        ins(3'd5, 16'hFFFF, 16'hFFFF, 16'h0, 0, 0);
        step();
        in_valid = 0;
        repeat (16) step();
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_stall_ov", out_valid, 0);
            chk("done_stall_busy", busy, 1);
        end
        stall_in = 0;
        step();
        chk("mul2_res", AluResult, 16'h0001);
        chk("mul2_ov", out_valid, 1);
        chk("mul2_busy", busy, 0);
        ins(3'd5, 16'h0003, 16'h0005, 16'h0, 0, 0);
        step();
        in_valid = 0;
        repeat (4) step();
        flush = 1;
        step();
        flush = 0;
        chk("flush_busy", busy, 0);
        chk("flush_sig", signals, 0);
        chk("flush_rw", RegWr, 0);
        chk("flush_ov", out_valid, 0);
        seen = 0;
        repeat (25) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("flush_no_product", seen, 0);
        ins(3'd1, 16'h0001, 16'h0001, 16'h0, 0, 0);
        step();
        chk("pre_flush_ov", out_valid, 1);
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush_valid_ov", out_valid, 0);
        chk("flush_valid_res", AluResult, 0);
        ins(3'd5, 16'h0002, 16'h0003, 16'h0, 0, 0);
        step();
        in_valid = 0;
        repeat (5) step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_mul_busy", busy, 0);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("rst_mul_no_product", seen, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
